// File: rtl/mips_core_pkg.sv
// Shared types and constants for the MIPS core rename stage.
package mips_core_pkg;

  localparam int NUM_PHYS = 64;
  localparam int NUM_ARCH = 32;

  typedef logic [5:0] PhysReg;
  typedef logic [4:0] MipsReg;

  // Number of set bits in a tag vector (free-list occupancy)
  function automatic logic [6:0] count_free(input logic [NUM_PHYS-1:0] vec);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < NUM_PHYS; i++) begin
      n = n + 7'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/free_list_alloc.sv
// Picks the lowest-numbered free physical tag from a free vector.
module free_list_alloc
  import mips_core_pkg::*;
(
  input  logic [NUM_PHYS-1:0] free_vec,
  output PhysReg              tag,
  output logic                found
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    tag   = '0;
    found = 1'b0;
    for (int i = NUM_PHYS - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        tag   = PhysReg'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_rename.sv
// Register rename stage: speculative/retirement maps, free list and
// per-tag ready bits, with a one-deep registered output toward the
// instruction queue.
module register_rename #(
  parameter int NUM_PHYS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                in_uses_rs,
  input  logic                in_uses_rt,
  input  logic                in_uses_rw,
  input  logic [4:0]          in_rs_addr,
  input  logic [4:0]          in_rt_addr,
  input  logic [4:0]          in_rw_addr,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [5:0]          out_rs_phys,
  output logic [5:0]          out_rt_phys,
  output logic [5:0]          out_rw_phys,
  output logic [5:0]          out_old_rw_phys,
  output logic                out_uses_rs,
  output logic                out_uses_rt,
  output logic                out_uses_rw,
  input  logic                wb_valid,
  input  logic [5:0]          wb_phys,
  input  logic                commit_valid,
  input  logic [4:0]          commit_rw_arch,
  input  logic [5:0]          commit_rw_phys,
  input  logic [5:0]          commit_old_phys,
  input  logic                flush,
  output logic [NUM_PHYS-1:0] phys_ready,
  output logic [6:0]          free_count
);

  import mips_core_pkg::PhysReg;
  import mips_core_pkg::NUM_ARCH;
  import mips_core_pkg::count_free;

  PhysReg spec_map      [NUM_ARCH];
  PhysReg spec_map_nx   [NUM_ARCH];
  PhysReg retire_map    [NUM_ARCH];
  PhysReg retire_map_nx [NUM_ARCH];

  logic [NUM_PHYS-1:0] free_vec;
  logic [NUM_PHYS-1:0] free_nx;
  logic [NUM_PHYS-1:0] ready_vec;
  logic [NUM_PHYS-1:0] ready_nx;
  logic [NUM_PHYS-1:0] ref_vec;
  logic [6:0]          free_count_nx;

  PhysReg alloc_tag;
  logic   alloc_found;
  logic   fire;
  logic   do_alloc;

  free_list_alloc u_alloc (
    .free_vec (free_vec),
    .tag      (alloc_tag),
    .found    (alloc_found)
  );

  assign in_ready = (!out_valid || out_ready) && !flush &&
                    (!in_uses_rw || (in_rw_addr == 5'd0) || (free_count != 7'd0));

  assign fire     = in_valid && in_ready;
  assign do_alloc = fire && in_uses_rw && (in_rw_addr != 5'd0) && alloc_found;

  assign phys_ready = ready_vec;

  // Next state of maps and tag vectors; flush applied last so it overrides everything
  always_comb begin
    spec_map_nx   = spec_map;
    retire_map_nx = retire_map;
    free_nx       = free_vec;
    ready_nx      = ready_vec;
    ref_vec       = '0;

    if (commit_valid && (commit_rw_arch != 5'd0)) begin
      retire_map_nx[commit_rw_arch] = commit_rw_phys;
      if (commit_old_phys != 6'd0) begin
        free_nx[commit_old_phys] = 1'b1;
      end
    end

    if (wb_valid) begin
      ready_nx[wb_phys] = 1'b1;
    end

    if (do_alloc) begin
      spec_map_nx[in_rw_addr] = alloc_tag;
      free_nx[alloc_tag]      = 1'b0;
      ready_nx[alloc_tag]     = 1'b0;
    end

    if (flush) begin
      spec_map_nx = retire_map_nx;
      for (int i = 0; i < NUM_ARCH; i++) begin
        ref_vec[retire_map_nx[i]] = 1'b1;
      end
      free_nx    = ~ref_vec;
      free_nx[0] = 1'b0;
      ready_nx   = '1;
    end

    free_count_nx = count_free(free_nx);
  end

  // Map and tag-vector state; reset restores the identity mapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        spec_map[i]   <= PhysReg'(i);
        retire_map[i] <= PhysReg'(i);
      end
      for (int i = 0; i < NUM_PHYS; i++) begin
        free_vec[i] <= (i >= NUM_ARCH);
      end
      ready_vec  <= '1;
      free_count <= 7'(NUM_PHYS - NUM_ARCH);
    end else begin
      spec_map   <= spec_map_nx;
      retire_map <= retire_map_nx;
      free_vec   <= free_nx;
      ready_vec  <= ready_nx;
      free_count <= free_count_nx;
    end
  end

  // Output register: capture on accept, hold while stalled, drop on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_rs_phys     <= '0;
      out_rt_phys     <= '0;
      out_rw_phys     <= '0;
      out_old_rw_phys <= '0;
      out_uses_rs     <= 1'b0;
      out_uses_rt     <= 1'b0;
      out_uses_rw     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid       <= 1'b1;
      out_rs_phys     <= spec_map[in_rs_addr];
      out_rt_phys     <= spec_map[in_rt_addr];
      out_rw_phys     <= do_alloc ? alloc_tag : 6'd0;
      out_old_rw_phys <= do_alloc ? spec_map[in_rw_addr] : 6'd0;
      out_uses_rs     <= in_uses_rs;
      out_uses_rt     <= in_uses_rt;
      out_uses_rw     <= in_uses_rw;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_register_rename.sv
// Testbench for register_rename: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_register_rename;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_uses_rs, in_uses_rt, in_uses_rw;
  logic [4:0]  in_rs_addr, in_rt_addr, in_rw_addr;
  logic        in_ready, out_valid, out_ready;
  logic [5:0]  out_rs_phys, out_rt_phys, out_rw_phys, out_old_rw_phys;
  logic        out_uses_rs, out_uses_rt, out_uses_rw;
  logic        wb_valid;
  logic [5:0]  wb_phys;
  logic        commit_valid;
  logic [4:0]  commit_rw_arch;
  logic [5:0]  commit_rw_phys, commit_old_phys;
  logic        flush;
  logic [63:0] phys_ready;
  logic [6:0]  free_count;

  register_rename #(.NUM_PHYS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt), .in_uses_rw(in_uses_rw),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rw_addr(in_rw_addr),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs_phys(out_rs_phys), .out_rt_phys(out_rt_phys), .out_rw_phys(out_rw_phys),
    .out_old_rw_phys(out_old_rw_phys), .out_uses_rs(out_uses_rs), .out_uses_rt(out_uses_rt),
    .out_uses_rw(out_uses_rw), .wb_valid(wb_valid), .wb_phys(wb_phys),
    .commit_valid(commit_valid), .commit_rw_arch(commit_rw_arch),
    .commit_rw_phys(commit_rw_phys), .commit_old_phys(commit_old_phys),
    .flush(flush), .phys_ready(phys_ready), .free_count(free_count)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [5:0]  m_map    [32];
  logic [5:0]  m_retire [32];
  logic [63:0] m_free, m_ready;
  logic        m_out_valid;
  logic [5:0]  m_rs, m_rt, m_rw, m_old;
  logic        m_urs, m_urt, m_urw;

  typedef struct {
    logic [4:0] arch;
    logic [5:0] phys;
    logic [5:0] old;
  } retire_t;
  retire_t cq[$];

  typedef struct {
    logic       urw;
    logic [4:0] rs, rt, rw;
    logic [5:0] exp_rs, exp_rt, exp_rw, exp_old;
    logic [6:0] exp_fc;
    int         chk_tag;
    logic       chk_rdy;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  logic last_in_ready;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic modelInReady();
    return (!m_out_valid || out_ready) && !flush &&
           (!in_uses_rw || in_rw_addr == 5'd0 || $countones(m_free) != 0);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      m_map[i]    = 6'(i);
      m_retire[i] = 6'(i);
    end
    m_free      = {32'hFFFF_FFFF, 32'h0};
    m_ready     = '1;
    m_out_valid = 1'b0;
    m_rs = '0; m_rt = '0; m_rw = '0; m_old = '0;
    m_urs = 1'b0; m_urt = 1'b0; m_urw = 1'b0;
    cq.delete();
  endtask

  task automatic modelStep();
    logic       fire;
    int         lowest;
    logic [5:0] tag, rs_tag, rt_tag, old_tag;
    fire   = in_valid && modelInReady();
    lowest = -1;
    for (int t = 0; t < 64; t++) begin
      if (m_free[t] && lowest < 0) lowest = t;
    end
    rs_tag  = m_map[in_rs_addr];
    rt_tag  = m_map[in_rt_addr];
    tag     = '0;
    old_tag = '0;
    if (commit_valid && commit_rw_arch != 5'd0) begin
      m_retire[commit_rw_arch] = commit_rw_phys;
      if (commit_old_phys != 6'd0) m_free[commit_old_phys] = 1'b1;
    end
    if (wb_valid) m_ready[wb_phys] = 1'b1;
    if (fire && in_uses_rw && in_rw_addr != 5'd0) begin
      tag                = 6'(lowest);
      old_tag            = m_map[in_rw_addr];
      m_map[in_rw_addr]  = tag;
      m_free[tag]        = 1'b0;
      m_ready[tag]       = 1'b0;
    end
    if (flush) begin
      m_free = '1;
      for (int i = 0; i < 32; i++) begin
        m_map[i] = m_retire[i];
        m_free[m_retire[i]] = 1'b0;
      end
      m_free[0]   = 1'b0;
      m_ready     = '1;
      m_out_valid = 1'b0;
      cq.delete();
    end else if (fire) begin
      m_out_valid = 1'b1;
      m_rs = rs_tag; m_rt = rt_tag; m_rw = tag; m_old = old_tag;
      m_urs = in_uses_rs; m_urt = in_uses_rt; m_urw = in_uses_rw;
      cq.push_back('{arch: (in_uses_rw ? in_rw_addr : 5'd0), phys: tag, old: old_tag});
    end else if (out_ready) begin
      m_out_valid = 1'b0;
    end
  endtask

  task automatic compareAll();
    checkOutput("out_valid", 64'(out_valid), 64'(m_out_valid));
    if (m_out_valid) begin
      checkOutput("out_rs_phys", 64'(out_rs_phys), 64'(m_rs));
      checkOutput("out_rt_phys", 64'(out_rt_phys), 64'(m_rt));
      checkOutput("out_rw_phys", 64'(out_rw_phys), 64'(m_rw));
      checkOutput("out_old_rw_phys", 64'(out_old_rw_phys), 64'(m_old));
      checkOutput("out_uses", 64'({out_uses_rs, out_uses_rt, out_uses_rw}), 64'({m_urs, m_urt, m_urw}));
    end
    checkOutput("free_count", 64'(free_count), 64'($countones(m_free)));
    checkOutput("phys_ready", phys_ready, m_ready);
  endtask

  task automatic setIdle();
    in_valid = 1'b0; in_uses_rs = 1'b0; in_uses_rt = 1'b0; in_uses_rw = 1'b0;
    in_rs_addr = '0; in_rt_addr = '0; in_rw_addr = '0;
    out_ready = 1'b1;
    wb_valid = 1'b0; wb_phys = '0;
    commit_valid = 1'b0; commit_rw_arch = '0; commit_rw_phys = '0; commit_old_phys = '0;
    flush = 1'b0;
  endtask

  // One clock: in_ready sampled at the falling edge, outputs 1 ns after the rising edge
  task automatic applyStimulus();
    @(negedge clk);
    last_in_ready = in_ready;
    checkOutput("in_ready", 64'(in_ready), 64'(modelInReady()));
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic doReset();
    setIdle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkOutput("reset free_count", 64'(free_count), 64'd32);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out_rw_phys", 64'(out_rw_phys), 64'd0);
    checkOutput("reset phys_ready", phys_ready, {64{1'b1}});
    rst_n = 1'b1;
    #1;
    compareAll();
  endtask

  initial begin
    vec_t    vecs[5];
    retire_t e;

    vecs[0] = '{urw: 1'b1, rs: 5'd5, rt: 5'd5, rw: 5'd5, exp_rs: 6'd5,  exp_rt: 6'd5,  exp_rw: 6'd32, exp_old: 6'd5,  exp_fc: 7'd31, chk_tag: 32, chk_rdy: 1'b0};
    vecs[1] = '{urw: 1'b1, rs: 5'd5, rt: 5'd5, rw: 5'd5, exp_rs: 6'd32, exp_rt: 6'd32, exp_rw: 6'd33, exp_old: 6'd32, exp_fc: 7'd30, chk_tag: 33, chk_rdy: 1'b0};
    vecs[2] = '{urw: 1'b1, rs: 5'd1, rt: 5'd2, rw: 5'd0, exp_rs: 6'd1,  exp_rt: 6'd2,  exp_rw: 6'd0,  exp_old: 6'd0,  exp_fc: 7'd30, chk_tag: 5,  chk_rdy: 1'b1};
    vecs[3] = '{urw: 1'b0, rs: 5'd9, rt: 5'd5, rw: 5'd3, exp_rs: 6'd9,  exp_rt: 6'd33, exp_rw: 6'd0,  exp_old: 6'd0,  exp_fc: 7'd30, chk_tag: 32, chk_rdy: 1'b0};
    vecs[4] = '{urw: 1'b1, rs: 5'd5, rt: 5'd0, rw: 5'd9, exp_rs: 6'd33, exp_rt: 6'd0,  exp_rw: 6'd34, exp_old: 6'd9,  exp_fc: 7'd29, chk_tag: 34, chk_rdy: 1'b0};

    doReset();

    // Directed vectors from reset
    for (int i = 0; i < 5; i++) begin
      setIdle();
      in_valid = 1'b1; in_uses_rs = 1'b1; in_uses_rt = 1'b1; in_uses_rw = vecs[i].urw;
      in_rs_addr = vecs[i].rs; in_rt_addr = vecs[i].rt; in_rw_addr = vecs[i].rw;
      applyStimulus();
      checkOutput($sformatf("vec%0d in_ready", i), 64'(last_in_ready), 64'd1);
      checkOutput($sformatf("vec%0d rs", i), 64'(out_rs_phys), 64'(vecs[i].exp_rs));
      checkOutput($sformatf("vec%0d rt", i), 64'(out_rt_phys), 64'(vecs[i].exp_rt));
      checkOutput($sformatf("vec%0d rw", i), 64'(out_rw_phys), 64'(vecs[i].exp_rw));
      checkOutput($sformatf("vec%0d old", i), 64'(out_old_rw_phys), 64'(vecs[i].exp_old));
      checkOutput($sformatf("vec%0d free_count", i), 64'(free_count), 64'(vecs[i].exp_fc));
      checkOutput($sformatf("vec%0d ready bit", i), 64'(phys_ready[vecs[i].chk_tag]), 64'(vecs[i].chk_rdy));
    end

    // Back-pressure: three stalled cycles hold the output and block allocation
    for (int k = 0; k < 3; k++) begin
      setIdle();
      in_valid = 1'b1; in_uses_rw = 1'b1; in_rw_addr = 5'd10; out_ready = 1'b0;
      applyStimulus();
      checkOutput("stall in_ready", 64'(last_in_ready), 64'd0);
      checkOutput("stall out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall rw held", 64'(out_rw_phys), 64'd34);
      checkOutput("stall old held", 64'(out_old_rw_phys), 64'd9);
      checkOutput("stall free_count", 64'(free_count), 64'd29);
    end

    // Release, with a writeback to the tag being allocated in the same cycle
    setIdle();
    in_valid = 1'b1; in_uses_rw = 1'b1; in_rw_addr = 5'd10; wb_valid = 1'b1; wb_phys = 6'd35;
    applyStimulus();
    checkOutput("release in_ready", 64'(last_in_ready), 64'd1);
    checkOutput("release rw", 64'(out_rw_phys), 64'd35);
    checkOutput("release old", 64'(out_old_rw_phys), 64'd10);
    checkOutput("release free_count", 64'(free_count), 64'd28);
    checkOutput("alloc beats wb", 64'(phys_ready[35]), 64'd0);

    setIdle();
    wb_valid = 1'b1; wb_phys = 6'd32;
    applyStimulus();
    checkOutput("wb sets ready", 64'(phys_ready[32]), 64'd1);

    // Exhaust the free list, then free tag 1 by commit
    doReset();
    for (int k = 0; k < 32; k++) begin
      setIdle();
      in_valid = 1'b1; in_uses_rw = 1'b1; in_rw_addr = 5'd1;
      applyStimulus();
    end
    checkOutput("exhaust free_count", 64'(free_count), 64'd0);
    checkOutput("exhaust last tag", 64'(out_rw_phys), 64'd63);
    setIdle();
    in_valid = 1'b1; in_uses_rw = 1'b1; in_rw_addr = 5'd1;
    commit_valid = 1'b1; commit_rw_arch = 5'd1; commit_rw_phys = 6'd32; commit_old_phys = 6'd1;
    applyStimulus();
    checkOutput("exhaust 33rd blocked", 64'(last_in_ready), 64'd0);
    checkOutput("commit frees one", 64'(free_count), 64'd1);
    setIdle();
    in_valid = 1'b1; in_uses_rw = 1'b1; in_rw_addr = 5'd1;
    applyStimulus();
    checkOutput("33rd accepted", 64'(last_in_ready), 64'd1);
    checkOutput("33rd tag", 64'(out_rw_phys), 64'd1);
    checkOutput("33rd old", 64'(out_old_rw_phys), 64'd63);
    checkOutput("33rd free_count", 64'(free_count), 64'd0);

    // Flush restores the retirement map
    doReset();
    setIdle();
    in_valid = 1'b1; in_uses_rw = 1'b1; in_rw_addr = 5'd7;
    applyStimulus();
    checkOutput("flushseq first tag", 64'(out_rw_phys), 64'd32);
    setIdle();
    in_valid = 1'b1; in_uses_rw = 1'b1; in_rw_addr = 5'd7;
    commit_valid = 1'b1; commit_rw_arch = 5'd7; commit_rw_phys = 6'd32; commit_old_phys = 6'd7;
    applyStimulus();
    checkOutput("flushseq second tag", 64'(out_rw_phys), 64'd33);
    checkOutput("flushseq second old", 64'(out_old_rw_phys), 64'd32);
    setIdle();
    flush = 1'b1;
    applyStimulus();
    checkOutput("flush out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush ready", phys_ready, {64{1'b1}});
    checkOutput("flush free_count", 64'(free_count), 64'd32);
    setIdle();
    in_valid = 1'b1; in_uses_rs = 1'b1; in_rs_addr = 5'd7; in_uses_rw = 1'b1; in_rw_addr = 5'd3;
    applyStimulus();
    checkOutput("flush map7", 64'(out_rs_phys), 64'd32);
    checkOutput("flush tag7 free", 64'(out_rw_phys), 64'd7);
    setIdle();
    in_valid = 1'b1; in_uses_rw = 1'b1; in_rw_addr = 5'd4;
    applyStimulus();
    checkOutput("flush tag33 free", 64'(out_rw_phys), 64'd33);

    // Randomized traffic against the model, with a reset partway through
    doReset();
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) doReset();
      setIdle();
      in_valid   = ($urandom_range(3) != 0);
      in_uses_rs = 1'($urandom_range(1));
      in_uses_rt = 1'($urandom_range(1));
      in_uses_rw = ($urandom_range(3) != 0);
      in_rs_addr = 5'($urandom_range(31));
      in_rt_addr = 5'($urandom_range(31));
      in_rw_addr = 5'($urandom_range(7));
      out_ready  = ($urandom_range(3) != 0);
      if (cq.size() > 0 && $urandom_range(2) == 0) begin
        e = cq.pop_front();
        commit_valid = 1'b1; commit_rw_arch = e.arch;
        commit_rw_phys = e.phys; commit_old_phys = e.old;
      end
      wb_valid = 1'($urandom_range(1));
      wb_phys  = 6'($urandom_range(63));
      flush    = ($urandom_range(49) == 0);
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
